key_debounce: RTL and testbench

Front-end stage for the vending machine's coin inputs. It synchronises raw, bouncing push-button levels, debounces each key with a per-key state machine, and emits clean single-cycle press pulses. It drives the coin accumulator's `key[1:0]` port directly. Its output is one-hot-or-zero every cycle, so no simultaneous press is ever dropped by the accumulator's priority logic.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_filter.sv | 110 +++++++++++
 rtl/key_debounce.sv | 72 +++++++
 tb/tb_key_debounce.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the coin-key debouncer: per-key FSM encoding and
// helpers that derive the debounce interval and counter width.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    // Number of clock cycles a new level must stay stable before acceptance.
    function automatic int db_cycles(input int clk_hz, input int debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

    // Width of the stability counter; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_filter.sv
// One key's front end: 2-flop synchroniser, polarity normalisation and the
// debounce FSM. `press` is a combinational one-cycle event on the cycle the
// FSM accepts a press; `level` is the debounced level the FSM is entering,
// so the parent can register both on the same edge as the state update.
//
//   state           | meaning
//   ----------------+----------------------------------------------------
//   ST_IDLE         | key released and stable
//   ST_PRESS_WAIT   | pressed level seen, counting stable cycles
//   ST_PRESSED      | press accepted, key held
//   ST_RELEASE_WAIT | released level seen while pressed, counting
module key_filter
    import key_pkg::*;
#(
    parameter int DB_CYCLES      = 4,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press,
    output logic level
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    // Raw pin value when the key is not pressed; also the synchroniser reset value.
    localparam logic          RAW_IDLE = (KEY_ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          s;
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Normalise so that s=1 always means pressed.
    assign s = sync2 ^ RAW_IDLE;

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter update and press event.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_nxt = ST_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_nxt = ST_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = ST_PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A key counts as held until its release has been confirmed.
    assign level = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_WAIT);

endmodule

// File: rtl/key_debounce.sv
// Coin-key front end: one debounce filter per key, then a priority arbiter
// that serialises simultaneous presses so key_pulse is one-hot-or-zero.
// Presses that lose arbitration are parked in `pend` and issued on the
// following cycles in index order; none are lost because a single key's
// events are more than DB_CYCLES apart and DB_CYCLES >= N_KEYS.
module key_debounce
    import key_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int N_KEYS         = 2,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_level
);

    localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] level_nxt;
    logic [N_KEYS-1:0] pend;
    logic [N_KEYS-1:0] pend_nxt;
    logic [N_KEYS-1:0] cand;
    logic [N_KEYS-1:0] grant;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_filter #(
            .DB_CYCLES      (DB_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_filter (
            .clk     (clk),
            .rst     (rst),
            .key_raw (key_in[g]),
            .press   (press[g]),
            .level   (level_nxt[g])
        );
    end

    assign cand = press | pend;

    // Lowest-index candidate wins; the rest wait in pend.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (cand[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        pend_nxt = cand & ~grant;
    end

    // Registered outputs and pending-press bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            key_pulse <= '0;
            key_level <= '0;
        end else begin
            pend      <= pend_nxt;
            key_pulse <= grant;
            key_level <= level_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4, active-low keys.
// Inputs change 1 ns after a rising edge; each tick() advances one edge and
// leaves time 1 ns past it, so outputs are read away from the clock edge.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] key_pulse;
    logic [1:0] key_level;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .CLK_HZ         (1000),
        .DEBOUNCE_MS    (4),
        .N_KEYS         (2),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_pulse (key_pulse),
        .key_level (key_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n edges, expecting given pulse/level values after each.
    task automatic run_expect(input int n, input string tag,
                              input logic [1:0] pulse_exp, input logic [1:0] level_exp);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_pulse"}, key_pulse, pulse_exp);
            chk({tag, "_level"}, key_level, level_exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 2'b11;
        tick(); tick(); tick();
        chk("reset_pulse", key_pulse, 2'b00);
        chk("reset_level", key_level, 2'b00);
        rst = 1'b0;
        run_expect(3, "idle", 2'b00, 2'b00);

        // Clean press of key 0: pulse at E6 only.
        key_in = 2'b10;
        run_expect(6, "p0_wait", 2'b00, 2'b00);   // E0..E5
        tick();                                     // E6
        chk("p0_pulse", key_pulse, 2'b01);
        chk("p0_level", key_level, 2'b01);
        run_expect(4, "p0_hold", 2'b00, 2'b01);    // E7..E10

        // Short release (4 samples) keeps key 0 pressed, no second pulse.
        key_in = 2'b11;
        run_expect(4, "p0_shortrel", 2'b00, 2'b01);
        key_in = 2'b10;
        run_expect(8, "p0_rehold", 2'b00, 2'b01);

        // Full release: level stays through R5, drops at R6, never a pulse.
        key_in = 2'b11;
        run_expect(6, "p0_rel_wait", 2'b00, 2'b01); // R0..R5
        run_expect(1, "p0_rel_done", 2'b00, 2'b00); // R6
        run_expect(3, "p0_rel_idle", 2'b00, 2'b00);

        // Bounce on key 1: 2 cycles pressed / 2 released for 20 cycles.
        for (int i = 0; i < 10; i++) begin
            key_in = (i % 2 == 0) ? 2'b01 : 2'b11;
            run_expect(2, "b1_bounce", 2'b00, 2'b00);
        end
        key_in = 2'b01;
        run_expect(6, "b1_wait", 2'b00, 2'b00);    // F0..F5
        tick();                                     // F6
        chk("b1_pulse", key_pulse, 2'b10);
        chk("b1_level", key_level, 2'b10);
        run_expect(3, "b1_hold", 2'b00, 2'b10);
        key_in = 2'b11;
        run_expect(6, "b1_rel_wait", 2'b00, 2'b10);
        run_expect(2, "b1_rel_done", 2'b00, 2'b00);

        // Simultaneous press: key 0 at E6, deferred key 1 at E7.
        key_in = 2'b00;
        run_expect(6, "sim_wait", 2'b00, 2'b00);
        tick();                                     // E6
        chk("sim_pulse_k0", key_pulse, 2'b01);
        chk("sim_level_e6", key_level, 2'b11);
        tick();                                     // E7
        chk("sim_pulse_k1", key_pulse, 2'b10);
        run_expect(3, "sim_hold", 2'b00, 2'b11);
        key_in = 2'b11;
        run_expect(6, "sim_rel_wait", 2'b00, 2'b11);
        run_expect(2, "sim_rel_done", 2'b00, 2'b00);

        // Glitch of 4 samples on key 0: filtered completely.
        key_in = 2'b10;
        tick(); tick(); tick(); tick();
        chk("gl4_pulse", key_pulse, 2'b00);
        chk("gl4_level", key_level, 2'b00);
        key_in = 2'b11;
        run_expect(12, "gl4_after", 2'b00, 2'b00);

        // Boundary: 5 samples is just long enough to be accepted.
        key_in = 2'b10;
        run_expect(5, "gl5_in", 2'b00, 2'b00);     // E0..E4
        key_in = 2'b11;
        run_expect(1, "gl5_e5", 2'b00, 2'b00);     // E5
        tick();                                     // E6
        chk("gl5_pulse", key_pulse, 2'b01);
        chk("gl5_level", key_level, 2'b01);
        run_expect(4, "gl5_relwait", 2'b00, 2'b01); // E7..E10
        run_expect(3, "gl5_done", 2'b00, 2'b00);    // E11..

        // Reset in PRESS_WAIT at cnt=2 with key held.
        key_in = 2'b10;
        run_expect(5, "rst_pre", 2'b00, 2'b00);    // E0..E4, cnt=2 after E4
        rst = 1'b1;
        tick();
        chk("rst_mid_pulse", key_pulse, 2'b00);
        chk("rst_mid_level", key_level, 2'b00);
        rst = 1'b0;
        run_expect(6, "rst_wait", 2'b00, 2'b00);   // E0'..E5'
        tick();                                     // E6'
        chk("rst_pulse", key_pulse, 2'b01);
        chk("rst_level", key_level, 2'b01);
        run_expect(3, "rst_hold", 2'b00, 2'b01);

        // Reset while PRESSED: level clears, held key is a fresh press.
        rst = 1'b1;
        tick();
        chk("rst_held_level", key_level, 2'b00);
        chk("rst_held_pulse", key_pulse, 2'b00);
        rst = 1'b0;
        run_expect(6, "rst2_wait", 2'b00, 2'b00);
        tick();
        chk("rst2_pulse", key_pulse, 2'b01);
        chk("rst2_level", key_level, 2'b01);
        key_in = 2'b11;
        run_expect(6, "rst2_rel_wait", 2'b00, 2'b01);
        run_expect(2, "rst2_rel_done", 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
